// File: rtl/uart_tx_port.sv
// uart_tx_port: memory-mapped 8N1 serial transmitter for the f8 data bus.
//
// A CPU write to BASE_ADDR queues dwrite_data[7:0] in a small FIFO. A write to
// BASE_ADDR+2 clears the sticky overflow flag. The FSM pops bytes and shifts
// them out LSB first on txd, with one start bit, eight data bits and one stop
// bit. Each bit lasts CLKS_PER_BIT cycles.
//
// Ports:
//   clk, reset            system clock; synchronous active-high reset
//   dwrite_addr/data/en   CPU data write port (only data[7:0] is used)
//   dread_addr            CPU data read address
//   status_data           STATUS word when status_sel is high, else 0
//   status_sel            dread_addr hits the STATUS register
//   txd                   serial output, idle high
//   busy                  a frame is shifting or bytes are still queued
//
// STATUS layout: [0] full, [1] empty, [2] tx_active, [3] overflow,
//                [7:4] FIFO count, [15:8] zero.
module uart_tx_port #(
  parameter logic [15:0] BASE_ADDR    = 16'hff00,
  parameter int          CLKS_PER_BIT = 4,
  parameter int          FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] dwrite_addr,
  input  logic [15:0] dwrite_data,
  input  logic        dwrite_en,
  input  logic [15:0] dread_addr,
  output logic [15:0] status_data,
  output logic        status_sel,
  output logic        txd,
  output logic        busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int NW = AW + 1;

  localparam logic [15:0]   STAT_ADDR = BASE_ADDR + 16'd2;
  localparam logic [CW-1:0] CLK_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [NW-1:0] DEPTH_N   = NW'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t          state;
  logic [CW-1:0]   clk_cnt;
  logic [2:0]      bit_idx;
  logic [7:0]      shift;

  logic [7:0]      mem [FIFO_DEPTH];
  logic [AW-1:0]   rd_ptr;
  logic [AW-1:0]   wr_ptr;
  logic [NW-1:0]   count;
  logic            overflow;

  logic            full;
  logic            empty;
  logic            bit_end;
  logic            pop;
  logic            push_req;
  logic            clr_req;
  logic            push_ok;
  logic [7:0]      head;
  logic [3:0]      cnt4;

  // The upper data byte has no meaning for this register.
  logic            unused_hi;
  assign unused_hi = ^dwrite_data[15:8];

  assign full     = (count == DEPTH_N);
  assign empty    = (count == '0);
  assign bit_end  = (clk_cnt == CLK_LAST);
  assign head     = mem[rd_ptr];

  assign push_req = dwrite_en && (dwrite_addr == BASE_ADDR);
  assign clr_req  = dwrite_en && (dwrite_addr == STAT_ADDR);

  // The FSM takes a byte either when it sits idle, or on the last stop-bit
  // cycle so the next start bit follows with no idle gap.
  assign pop      = !empty && ((state == IDLE) || ((state == STOP) && bit_end));

  // A push into a full FIFO still fits when a pop frees a slot on the same edge.
  assign push_ok  = push_req && (!full || pop);

  assign busy     = (state != IDLE) || !empty;

  // ---------------------------------------------------------------------------
  // Transmit FIFO
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (push_ok && !reset) mem[wr_ptr] <= dwrite_data[7:0];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + AW'(1);
      if (pop)     rd_ptr <= rd_ptr + AW'(1);
      unique case ({push_ok, pop})
        2'b10:   count <= count + NW'(1);
        2'b01:   count <= count - NW'(1);
        default: count <= count;
      endcase
      // Clear and push never coincide: there is one write address per cycle.
      if (clr_req)                overflow <= 1'b0;
      else if (push_req && !push_ok) overflow <= 1'b1;
    end
  end

  // ---------------------------------------------------------------------------
  // Serial FSM. txd is registered and always updated together with state, so
  // the line level reflects the state the FSM is entering.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      clk_cnt <= '0;
      bit_idx <= '0;
      shift   <= '0;
      txd     <= 1'b1;
    end else begin
      unique case (state)
        IDLE: begin
          txd     <= 1'b1;
          clk_cnt <= '0;
          if (!empty) begin
            shift <= head;
            state <= START;
            txd   <= 1'b0;
          end
        end

        START: begin
          if (bit_end) begin
            clk_cnt <= '0;
            bit_idx <= '0;
            state   <= DATA;
            txd     <= shift[0];
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        DATA: begin
          if (bit_end) begin
            clk_cnt <= '0;
            shift   <= shift >> 1;
            if (bit_idx == 3'd7) begin
              state <= STOP;
              txd   <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              // Next bit is the one that shifts into position 0.
              txd     <= shift[1];
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        STOP: begin
          if (bit_end) begin
            clk_cnt <= '0;
            if (!empty) begin
              shift <= head;
              state <= START;
              txd   <= 1'b0;
            end else begin
              state <= IDLE;
              txd   <= 1'b1;
            end
          end else begin
            clk_cnt <= clk_cnt + CW'(1);
          end
        end

        default: begin
          state <= IDLE;
          txd   <= 1'b1;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // STATUS read path, combinational from the read address and current state.
  // ---------------------------------------------------------------------------
  assign cnt4 = 4'(count);

  always_comb begin
    status_sel  = (dread_addr == STAT_ADDR);
    status_data = 16'h0000;
    if (status_sel)
      status_data = {8'h00, cnt4, overflow, (state != IDLE), empty, full};
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Testbench for uart_tx_port (defaults: BASE 16'hff00, 4 clocks/bit, 4-entry
// FIFO). Stimulus pushes expected frames into a queue; an independent monitor
// decodes txd, pops the queue and compares whole sampled frames.
module tb_uart_tx_port;

  localparam int CPB   = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk;
  logic        reset;
  logic [15:0] dwrite_addr;
  logic [15:0] dwrite_data;
  logic        dwrite_en;
  logic [15:0] dread_addr;
  logic [15:0] status_data;
  logic        status_sel;
  logic        txd;
  logic        busy;

  uart_tx_port dut (
    .clk         (clk),
    .reset       (reset),
    .dwrite_addr (dwrite_addr),
    .dwrite_data (dwrite_data),
    .dwrite_en   (dwrite_en),
    .dread_addr  (dread_addr),
    .status_data (status_data),
    .status_sel  (status_sel),
    .txd         (txd),
    .busy        (busy)
  );

  typedef struct {
    logic [7:0] data;
    logic       b2b;   // frame must start exactly FRAME cycles after the previous one
  } exp_t;

  exp_t exp_q[$];
  int   cyc = 0;
  int   n_cmp = 0;
  int   n_err = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    n_cmp++;
    if (act !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp_v, cyc);
    end
  endtask

  function automatic logic [39:0] frame_of(input logic [7:0] b);
    logic [39:0] v;
    v = '0;
    for (int k = 0; k < FRAME; k++) begin
      int slot;
      slot = k / CPB;
      if (slot == 0)      v[k] = 1'b0;
      else if (slot == 9) v[k] = 1'b1;
      else                v[k] = b[slot-1];
    end
    return v;
  endfunction

  // ---------------------------------------------------------------------------
  // Monitor: samples txd on the falling clock edge, one sample per cycle.
  // ---------------------------------------------------------------------------
  initial begin
    logic [39:0] samp;
    logic [7:0]  got;
    int          start;
    int          last_start;
    bit          aborted;
    bit          prev;
    exp_t        e;
    prev       = 1'b1;
    last_start = -1000;
    forever begin
      @(negedge clk);
      if (reset) begin
        prev = 1'b1;
        continue;
      end
      if (prev && !txd) begin
        start   = cyc;
        samp    = '0;
        aborted = 1'b0;
        for (int k = 1; k < FRAME; k++) begin
          @(negedge clk);
          if (reset) begin
            aborted = 1'b1;
            break;
          end
          samp[k] = txd;
        end
        if (aborted) begin
          prev = 1'b1;
          continue;
        end
        for (int b = 0; b < 8; b++) got[b] = samp[CPB*(b+1) + CPB/2];
        if (exp_q.size() == 0) begin
          chk("unexpected_frame", 64'(got), 64'h1_0000);
        end else begin
          e = exp_q.pop_front();
          chk("frame_byte", 64'(got), 64'(e.data));
          chk("frame_wave", 64'(samp), 64'(frame_of(e.data)));
          if (e.b2b) chk("frame_gap", 64'(start - last_start), 64'(FRAME));
        end
        last_start = start;
        prev       = samp[FRAME-1];
      end else begin
        prev = txd;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stimulus helpers. All run at #1 after a rising edge.
  // ---------------------------------------------------------------------------
  task automatic wr(input logic [15:0] a, input logic [7:0] d, output int edge_n);
    dwrite_addr = a;
    dwrite_data = {8'hc3, d};   // junk upper byte must be ignored
    dwrite_en   = 1'b1;
    @(posedge clk);
    #1;
    dwrite_en   = 1'b0;
    edge_n      = cyc;
  endtask

  task automatic wait_until(input int e);
    while (cyc < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while (busy && n < 600) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("idle_timeout", 64'(busy), 64'd0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    int          n;
    int          e0;
    int          ed;
    logic [7:0]  ovf_bytes [5];
    logic [7:0]  fill_bytes[4];

    ovf_bytes  = '{8'h21, 8'h32, 8'h43, 8'h54, 8'h65};
    fill_bytes = '{8'h92, 8'hA4, 8'hB8, 8'hC3};

    reset       = 1'b1;
    dwrite_addr = 16'h0000;
    dwrite_data = 16'h0000;
    dwrite_en   = 1'b0;
    dread_addr  = 16'hff02;

    // Reset then idle
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    chk("rst_status", 64'(status_data), 64'h0002);
    chk("rst_sel", 64'(status_sel), 64'd1);
    for (int i = 0; i < 20; i++) begin
      chk("idle_txd", 64'(txd), 64'd1);
      chk("idle_busy", 64'(busy), 64'd0);
      @(posedge clk);
      #1;
    end
    dread_addr = 16'hff00;
    #1;
    chk("nosel_sel", 64'(status_sel), 64'd0);
    chk("nosel_data", 64'(status_data), 64'h0000);
    dread_addr = 16'hff02;
    // Writes to unrelated addresses do nothing.
    wr(16'hff01, 8'h99, ed);
    wr(16'h1234, 8'h98, ed);
    chk("stray_write", 64'(status_data), 64'h0002);

    // Single byte 0x55
    exp_q.push_back('{8'h55, 1'b0});
    wr(16'hff00, 8'h55, e0);
    chk("single_q_status", 64'(status_data), 64'h0010);
    chk("single_q_txd", 64'(txd), 64'd1);
    @(posedge clk);
    #1;
    chk("single_start_txd", 64'(txd), 64'd0);
    chk("single_start_status", 64'(status_data), 64'h0006);
    n = 0;
    while (busy && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    chk("single_busy_len", 64'(n), 64'd40);
    wait_idle();

    // Back-to-back: the second push lands on the edge that pops the first
    exp_q.push_back('{8'hA3, 1'b0});
    exp_q.push_back('{8'h0F, 1'b1});
    wr(16'hff00, 8'hA3, e0);
    chk("b2b_cnt1", 64'(status_data), 64'h0010);
    wr(16'hff00, 8'h0F, ed);
    chk("b2b_cnt1b", 64'(status_data), 64'h0014);
    wait_until(e0 + 40);
    chk("b2b_stop_status", 64'(status_data), 64'h0014);
    wait_until(e0 + 41);
    chk("b2b_cnt0", 64'(status_data), 64'h0006);
    chk("b2b_restart_txd", 64'(txd), 64'd0);
    wait_idle();

    // Overflow: 4 bytes fit behind the active frame, the fifth is dropped
    exp_q.push_back('{8'h11, 1'b0});
    for (int i = 0; i < 4; i++) exp_q.push_back('{ovf_bytes[i], 1'b1});
    wr(16'hff00, 8'h11, e0);
    wait_until(e0 + 4);
    for (int i = 0; i < 4; i++) wr(16'hff00, ovf_bytes[i], ed);
    chk("ovf_full", 64'(status_data), 64'h0045);
    wr(16'hff00, ovf_bytes[4], ed);
    chk("ovf_set", 64'(status_data), 64'h004D);
    wr(16'hff02, 8'h00, ed);
    chk("ovf_clear", 64'(status_data), 64'h0045);
    wait_idle();

    // Push into a full FIFO on the same edge as the STOP-end pop
    exp_q.push_back('{8'h81, 1'b0});
    for (int i = 0; i < 4; i++) exp_q.push_back('{fill_bytes[i], 1'b1});
    exp_q.push_back('{8'hD6, 1'b1});
    wr(16'hff00, 8'h81, e0);
    wr(16'hff00, fill_bytes[0], ed);
    chk("pp_cnt_after_pop", 64'(status_data), 64'h0014);
    for (int i = 1; i < 4; i++) wr(16'hff00, fill_bytes[i], ed);
    chk("pp_full", 64'(status_data), 64'h0045);
    wait_until(e0 + 40);
    wr(16'hff00, 8'hD6, ed);
    chk("pp_edge", 64'(ed), 64'(e0 + 41));
    chk("pp_status", 64'(status_data), 64'h0045);
    wait_idle();

    // Reset during DATA bit 3 with two bytes queued
    exp_q.push_back('{8'h3C, 1'b0});
    exp_q.push_back('{8'h5A, 1'b1});
    exp_q.push_back('{8'h7E, 1'b1});
    wr(16'hff00, 8'h3C, e0);
    wr(16'hff00, 8'h5A, ed);
    wr(16'hff00, 8'h7E, ed);
    chk("mid_queued", 64'(status_data), 64'h0024);
    wait_until(e0 + 17);
    reset = 1'b1;
    @(posedge clk);
    #1;
    chk("mid_txd", 64'(txd), 64'd1);
    chk("mid_status", 64'(status_data), 64'h0002);
    chk("mid_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    exp_q.delete();
    repeat (100) @(posedge clk);
    #1;
    chk("post_rst_txd", 64'(txd), 64'd1);
    chk("post_rst_busy", 64'(busy), 64'd0);
    chk("post_rst_status", 64'(status_data), 64'h0002);

    chk("all_frames_seen", 64'(exp_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
